// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and elaboration helpers for the serial adder.
//   state_e     : controller states (IDLE, RUN, DONE)
//   cnt_width() : width of the digit-step counter for a given step count
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // $clog2 of 1 or 2 would give 0 or 1.
  // A counter needs at least one bit, so the result is clamped to 1.
  function automatic int cnt_width(input int steps);
    return (steps <= 2) ? 1 : $clog2(steps);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit ripple-carry adder. It is the full-adder cell widened
// to one digit of the serial datapath.
//   x, y : digit operands
//   cin  : carry in from the previous digit
//   s    : digit sum
//   co   : carry out of the digit
// -----------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  always_comb begin
    // NOTE: every variable driven here gets a value before any conditional or
    // loop path. That guarantees a purely combinational block with no latch.
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[DIGIT];

endmodule : digit_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Multi-cycle add/subtract unit. It processes DIGIT bits per clock and keeps
// the carry in a register between digits. Operands arrive on one valid/ready
// handshake and the result leaves on another.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, sub)
//   a, b                : WIDTH-bit operands
//   sub                 : 0 = a+b, 1 = a-b (sampled only at accept)
//   out_valid/out_ready : result handshake
//   sum                 : WIDTH-bit result, modulo 2^WIDTH
//   cout                : final carry (for subtraction, 1 = no borrow)
//   overflow            : two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(STEPS);

  // Reject illegal geometries at elaboration time. A bad geometry must never
  // produce a silently truncated datapath.
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;

  logic [DIGIT-1:0]   dig_s;
  logic               dig_co;
  logic [WIDTH-1:0]   sum_shifted;
  logic [WIDTH-1:0]   b_eff;
  logic               accept;
  logic               last_step;

  // Subtraction is a + ~b + 1. The +1 enters as the initial carry.
  assign b_eff     = b ^ {WIDTH{sub}};
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .x   (a_sh_q[DIGIT-1:0]),
    .y   (b_sh_q[DIGIT-1:0]),
    .cin (carry_q),
    .s   (dig_s),
    .co  (dig_co)
  );

  // The result is built LSB digit first. Each new digit enters at the MSB
  // end, so after STEPS shifts the first digit reaches bit 0.
  if (DIGIT == WIDTH) begin : g_sum_single
    assign sum_shifted = dig_s;
  end else begin : g_sum_shift
    assign sum_shifted = {dig_s, sum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        sum_d   = sum_shifted;
        carry_d = dig_co;
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d = DONE;
          cout_d  = dig_co;
          ovf_d   = (a_msb_q == b_msb_q) && (sum_shifted[WIDTH-1] != a_msb_q);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept is possible only in IDLE or in DONE while the result drains.
    // In both cases it overrides the transition above and loads new operands.
    if (accept) begin
      state_d = RUN;
      a_sh_d  = a;
      b_sh_d  = b_eff;
      carry_d = sub;
      cnt_d   = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b_eff[WIDTH-1];
    end
  end

  // NOTE: state registers use non-blocking assignments. All flops then update
  // together from values sampled before the edge, which avoids ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder.
//   dut     : default geometry (WIDTH=8,  DIGIT=1)
//   dut_w16 : wide geometry    (WIDTH=16, DIGIT=4)
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid, in_ready, sub, out_valid, out_ready, cout, overflow;
  logic [7:0] a, b, sum;

  logic        w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready, w_cout, w_overflow;
  logic [15:0] w_a, w_b, w_sum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut_w16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .a         (w_a),
    .b         (w_b),
    .sub       (w_sub),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .sum       (w_sum),
    .cout      (w_cout),
    .overflow  (w_overflow)
  );

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges from accept to out_valid on the 8-bit unit.
  // in_ready must stay low throughout RUN.
  task automatic wait_result(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s in_ready_in_run: got %b want 0 (cycle %0d)", name, in_ready, lat);
      end
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string name, input int lat,
                              input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
    n_checks++;
    if (lat !== 8) begin
      n_errors++;
      $display("FAIL %s latency: got %0d want 8", name, lat);
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s out_valid: got %b want 1", name, out_valid);
    end
    n_checks++;
    if ({sum, cout, overflow} !== {e_sum, e_cout, e_ovf}) begin
      n_errors++;
      $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               name, sum, cout, overflow, e_sum, e_cout, e_ovf);
    end
  endtask

  // A complete 8-bit operation: accept, wait, check, drain.
  task automatic do_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tsub, input logic [7:0] e_sum, input logic e_cout,
                       input logic e_ovf);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready);
    end
    a = ta; b = tb; sub = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sub = ~tsub;  // sub must only matter at accept
    wait_result(name, lat);
    check_result(name, lat, e_sum, e_cout, e_ovf);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s drain: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0; w_out_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({in_ready, out_valid, sum, cout, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b want 1 0 00 0 0",
               in_ready, out_valid, sum, cout, overflow);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ignored_handshake: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_add();
    do_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    do_op("sub_10_10", 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    a = 8'h03; b = 8'h04; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result("bp_first", lat);
    check_result("bp_first", lat, 8'h07, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({out_valid, in_ready, sum, cout, overflow} !== {1'b1, 1'b0, 8'h07, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b sum=%h cout=%b ovf=%b want 1 0 07 0 0",
                 i, out_valid, in_ready, sum, cout, overflow);
      end
    end
    a = 8'h02; b = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_ready_with_out_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_same_edge_accept: got out_valid=%b want 0", out_valid);
    end
    wait_result("bp_second", lat);
    check_result("bp_second", lat, 8'h05, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a = 8'h55; b = 8'h11; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 8'h00}) begin
      n_errors++;
      $display("FAIL mid_run_reset: got vld=%b rdy=%b sum=%h want 0 1 00", out_valid, in_ready, sum);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++;
      $display("FAIL mid_run_no_result: got %0d out_valid cycles want 0", seen);
    end
    do_op("after_reset_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
  endtask

  task automatic test_wide();
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic        vs [2];
    logic [17:0] vexp [2];  // {sum, cout, overflow}
    int lat;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vs[0] = 1'b0; vexp[0] = {16'h0000, 1'b1, 1'b0};
    va[1] = 16'h8000; vb[1] = 16'h0001; vs[1] = 1'b1; vexp[1] = {16'h7FFF, 1'b1, 1'b1};
    for (int k = 0; k < 2; k++) begin
      w_a = va[k]; w_b = vb[k]; w_sub = vs[k]; w_in_valid = 1'b1;
      tick();
      w_in_valid = 1'b0;
      lat = 0;
      while (!w_out_valid && lat < 40) begin
        tick();
        lat++;
      end
      n_checks++;
      if (lat !== 4) begin
        n_errors++;
        $display("FAIL wide_%0d latency: got %0d want 4", k, lat);
      end
      n_checks++;
      if ({w_sum, w_cout, w_overflow} !== vexp[k]) begin
        n_errors++;
        $display("FAIL wide_%0d result: got %h/%b/%b want %h/%b/%b", k, w_sum, w_cout,
                 w_overflow, vexp[k][17:2], vexp[k][1], vexp[k][0]);
      end
      w_out_ready = 1'b1;
      tick();
      w_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_adder
